// File: rtl/issue_pkg.sv
// Shared instruction-field definitions and the register-usage decoder used by
// the issue unit and the stage-1 decoder.
package issue_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [5:0]  R_TYPE_OP = 6'd0;

    typedef logic [4:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t src1;
        reg_idx_t src2;
        logic     src2_used;
        reg_idx_t dest;
    } instr_regs_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_STALL = 2'd2
    } issue_state_t;

    // R-type reads rs/rt and writes rd; every other opcode reads rs and writes rt.
    function automatic instr_regs_t decode_regs(input logic [31:0] instr);
        instr_regs_t r;
        r.src1 = instr[RS_HI:RS_LO];
        if (instr[OP_HI:OP_LO] == R_TYPE_OP) begin
            r.src2      = instr[RT_HI:RT_LO];
            r.src2_used = 1'b1;
            r.dest      = instr[RD_HI:RD_LO];
        end else begin
            r.src2      = 5'd0;
            r.src2_used = 1'b0;
            r.dest      = instr[RT_HI:RT_LO];
        end
        return r;
    endfunction

endpackage

// File: rtl/issue_fifo.sv
// Synchronous word FIFO; full/empty are told apart by an extra pointer bit.
module issue_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [31:0]              wdata_i,
    output logic [31:0]              rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem_q [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic [AW:0] wptr_d;
    logic [AW:0] rptr_d;
    logic        do_push_s;
    logic        do_pop_s;

    // Status flags and next pointer values from the current pointers.
    always_comb begin
        full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        empty_o   = (wptr_q == rptr_q);
        count_o   = wptr_q - rptr_q;
        rdata_o   = mem_q[rptr_q[AW-1:0]];
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wptr_d    = do_push_s ? wptr_q + {{AW{1'b0}}, 1'b1} : wptr_q;
        rptr_d    = do_pop_s  ? rptr_q + {{AW{1'b0}}, 1'b1} : rptr_q;
    end

    // Pointer registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/instr_issue.sv
// Instruction issue unit: buffers producer words and inserts NOP bubbles while
// the head word reads a register still being written by an in-flight word.
module instr_issue
    import issue_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int HAZARD_DIST = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            in_instr,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [31:0]            instruction,
    output logic                   issued,
    output logic [$clog2(DEPTH):0] occupancy,
    output logic [15:0]            bubble_count
);

    localparam int SB_DEPTH = HAZARD_DIST - 1;

    logic         full_s;
    logic         empty_s;
    logic         push_s;
    logic         pop_s;
    logic         hazard_s;
    logic [31:0]  head_s;
    instr_regs_t  head_regs_s;
    issue_state_t state_s;

    reg_idx_t     sb_q [SB_DEPTH];
    logic [31:0]  instruction_q;
    logic         issued_q;
    logic [15:0]  bubble_q;

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (in_instr),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .count_o (occupancy)
    );

    // Hazard check of the head word against every live scoreboard entry.
    always_comb begin
        head_regs_s = decode_regs(head_s);
        hazard_s    = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if ((sb_q[i] != 5'd0) &&
                ((head_regs_s.src1 == sb_q[i]) ||
                 (head_regs_s.src2_used && (head_regs_s.src2 == sb_q[i])))) begin
                hazard_s = 1'b1;
            end else begin
                hazard_s = hazard_s;
            end
        end
    end

    // Per-cycle issue decision and handshake.
    always_comb begin
        if (empty_s) begin
            state_s = ST_IDLE;
        end else if (hazard_s) begin
            state_s = ST_STALL;
        end else begin
            state_s = ST_ISSUE;
        end
        in_ready = !full_s && rst;
        push_s   = in_valid && in_ready;
        pop_s    = (state_s == ST_ISSUE) && rst;
    end

    // Registered outputs, bubble counter and destination scoreboard.
    always_ff @(posedge clk) begin
        if (!rst) begin
            instruction_q <= NOP_INSTR;
            issued_q      <= 1'b0;
            bubble_q      <= 16'd0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_q[i] <= 5'd0;
            end
        end else begin
            sb_q[0] <= pop_s ? head_regs_s.dest : 5'd0;
            for (int i = 1; i < SB_DEPTH; i++) begin
                sb_q[i] <= sb_q[i-1];
            end
            case (state_s)
                ST_ISSUE: begin
                    instruction_q <= head_s;
                    issued_q      <= 1'b1;
                end
                ST_STALL: begin
                    instruction_q <= NOP_INSTR;
                    issued_q      <= 1'b0;
                    if (bubble_q != 16'hFFFF) begin
                        bubble_q <= bubble_q + 16'd1;
                    end
                end
                default: begin
                    instruction_q <= NOP_INSTR;
                    issued_q      <= 1'b0;
                end
            endcase
        end
    end

    assign instruction  = instruction_q;
    assign issued       = issued_q;
    assign bubble_count = bubble_q;

endmodule

// File: tb/tb_instr_issue.sv
// Bench for instr_issue: directed scenarios plus random traffic, all compared
// against a queue-based issue model.
module tb_instr_issue;

    localparam int DEPTH = 4;
    localparam int HD    = 3;

    logic        clk;
    logic        rst;
    logic [31:0] in_instr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction;
    logic        issued;
    logic [2:0]  occupancy;
    logic [15:0] bubble_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mq [$];
    int          hist [$];
    logic [31:0] exp_instr;
    logic        exp_issued;
    int          mbub;

    bit saw_full;
    int max_occ;
    int n_issued;
    bit acc;

    instr_issue #(.DEPTH(DEPTH), .HAZARD_DIST(HD)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_instr     (in_instr),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instruction  (instruction),
        .issued       (issued),
        .occupancy    (occupancy),
        .bubble_count (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int dest_of(input logic [31:0] w);
        return ((w >> 26) == 0) ? int'((w >> 11) & 31) : int'((w >> 16) & 31);
    endfunction

    function automatic bit model_hazard(input logic [31:0] w);
        int rs = int'((w >> 21) & 31);
        int rt = int'((w >> 16) & 31);
        bit rtype = ((w >> 26) == 0);
        foreach (hist[i]) begin
            if (hist[i] != 0 && (rs == hist[i] || (rtype && rt == hist[i]))) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        mq.delete();
        hist.delete();
        repeat (HD - 1) hist.push_back(0);
        exp_instr  = 32'h0;
        exp_issued = 1'b0;
        mbub       = 0;
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic r, output bit accepted);
        logic exp_ready;
        int   d;
        @(negedge clk);
        in_valid = v;
        in_instr = w;
        rst      = r;
        #1;
        exp_ready = r && (mq.size() < DEPTH);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_ready});
        check("occupancy", {29'd0, occupancy}, mq.size());
        if (r && int'(occupancy) > max_occ) max_occ = int'(occupancy);
        if (r && v && in_ready === 1'b0) saw_full = 1'b1;
        accepted = v && exp_ready;
        if (!r) begin
            model_reset();
        end else begin
            d = 0;
            if (mq.size() == 0) begin
                exp_instr  = 32'h0;
                exp_issued = 1'b0;
            end else if (model_hazard(mq[0])) begin
                exp_instr  = 32'h0;
                exp_issued = 1'b0;
                if (mbub < 65535) mbub++;
            end else begin
                exp_instr  = mq.pop_front();
                exp_issued = 1'b1;
                d = dest_of(exp_instr);
            end
            hist.push_front(d);
            void'(hist.pop_back());
            if (accepted) mq.push_back(w);
        end
        @(posedge clk);
        #1;
        check("instruction", instruction, exp_instr);
        check("issued", {31'd0, issued}, {31'd0, exp_issued});
        check("bubble_count", {16'd0, bubble_count}, mbub);
        if (issued === 1'b1) n_issued++;
    endtask

    task automatic idle(input int n);
        bit a;
        repeat (n) step(1'b0, 32'h0, 1'b1, a);
    endtask

    task automatic push_word(input logic [31:0] w);
        bit a;
        int k;
        a = 1'b0;
        for (k = 0; k < 40 && !a; k++) step(1'b1, w, 1'b1, a);
        checks++;
        if (!a) begin
            failures++;
            $error("FAIL push_timeout observed=not_accepted expected=accepted word=%h", w);
        end
    endtask

    function automatic logic [31:0] chain_word(input int k);
        logic [31:0] w;
        if (k == 0) w = (32'd1 << 21) | (32'd2 << 16) | (32'd5 << 11);
        else w = (32'(4 + k) << 21) | (32'(4 + k) << 16) | (32'(5 + k) << 11);
        return w;
    endfunction

    initial begin
        logic [31:0] w;
        int op;
        saw_full = 1'b0;
        max_occ  = 0;
        n_issued = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_instr = 32'h0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset then idle
        step(1'b0, 32'h0, 1'b0, acc);
        step(1'b0, 32'h0, 1'b0, acc);
        step(1'b0, 32'h0, 1'b1, acc);
        check("rst_instr", instruction, 32'h0);
        check("rst_issued", {31'd0, issued}, 32'd0);
        @(negedge clk);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_occ", {29'd0, occupancy}, 32'd0);

        // Independent stream
        step(1'b1, 32'h00221800, 1'b1, acc);
        step(1'b1, 32'h20240005, 1'b1, acc);
        check("ind_first", instruction, 32'h00221800);
        step(1'b0, 32'h0, 1'b1, acc);
        check("ind_second", instruction, 32'h20240005);
        check("ind_issued", {31'd0, issued}, 32'd1);
        check("ind_bubbles", {16'd0, bubble_count}, 32'd0);
        idle(4);

        // RAW hazard
        step(1'b1, 32'h00221800, 1'b1, acc);
        step(1'b1, 32'h00622800, 1'b1, acc);
        check("raw_o1", instruction, 32'h00221800);
        step(1'b0, 32'h0, 1'b1, acc);
        check("raw_o2", instruction, 32'h0);
        step(1'b0, 32'h0, 1'b1, acc);
        check("raw_o3", instruction, 32'h0);
        step(1'b0, 32'h0, 1'b1, acc);
        check("raw_o4", instruction, 32'h00622800);
        check("raw_bubbles", {16'd0, bubble_count}, 32'd2);
        idle(4);

        // r0 exemption
        step(1'b1, 32'h00000000, 1'b1, acc);
        step(1'b1, 32'h00001000, 1'b1, acc);
        check("r0_first_issued", {31'd0, issued}, 32'd1);
        step(1'b0, 32'h0, 1'b1, acc);
        check("r0_second", instruction, 32'h00001000);
        check("r0_bubbles", {16'd0, bubble_count}, 32'd2);
        idle(4);

        // Full / backpressure with a dependent chain
        saw_full = 1'b0;
        max_occ  = 0;
        n_issued = 0;
        for (int k = 0; k < 8; k++) push_word(chain_word(k));
        idle(30);
        check("full_seen", {31'd0, saw_full}, 32'd1);
        check("full_max_occ", max_occ, 32'd4);
        check("full_issued_count", n_issued, 32'd8);

        // Reset mid-operation
        for (int k = 0; k < 4; k++) step(1'b1, chain_word(k), 1'b1, acc);
        @(negedge clk);
        check("mid_occ_before", {29'd0, occupancy}, 32'd3);
        step(1'b0, 32'h0, 1'b0, acc);
        check("mid_instr", instruction, 32'h0);
        check("mid_bubbles", {16'd0, bubble_count}, 32'd0);
        step(1'b1, chain_word(1), 1'b1, acc);
        check("mid_accept", {31'd0, acc}, 32'd1);
        step(1'b0, 32'h0, 1'b1, acc);
        check("mid_dep_issue", instruction, chain_word(1));
        check("mid_dep_bubbles", {16'd0, bubble_count}, 32'd0);
        idle(3);

        // Random traffic with small register numbers to provoke hazards
        for (int n = 0; n < 500; n++) begin
            op = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 63));
            w  = (32'(op) << 26) | (32'($urandom_range(0, 3)) << 21) |
                 (32'($urandom_range(0, 3)) << 16) | (32'($urandom_range(0, 3)) << 11) |
                 ($urandom & 32'h7FF);
            step(($urandom_range(0, 3) != 0), w, ($urandom_range(0, 79) != 0), acc);
        end
        idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_issue.md
# instr_issue

Instruction issue unit that sources the 32-bit `instruction` stream consumed by the three-stage ALU pipeline top level. It accepts instruction words from a producer (testbench, loader or fetch logic) over a valid/ready handshake and buffers them in a small FIFO. The pipeline has no forwarding, so the unit inserts NOP bubbles whenever the head instruction reads a register still being written by an in-flight instruction. Its output drives the pipeline's `instruction` input directly.

## Interface
- `DEPTH`, 4: FIFO entries; must be a power of two, ≥2.
- `HAZARD_DIST`, 3: minimum issue-slot distance between a writer and a dependent reader; scoreboard depth is `HAZARD_DIST-1`.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_instr`  in  32  instruction word from the producer.
- `in_valid`  in  1  `in_instr` is valid.
- `in_ready`  out  1  unit can accept a word this cycle.
- `instruction`  out  32  registered instruction to the pipeline; `32'h0` = NOP.
- `issued`  out  1  registered; 1 when `instruction` carries a real (dequeued) word.
- `occupancy`  out  $clog2(DEPTH)+1  number of FIFO entries in use.
- `bubble_count`  out  16  number of hazard bubbles inserted since reset; saturates at 16'hFFFF.

## Operation
- Encoding (package constants):
  - `op` = [31:26], `rs` = [25:21], `rt` = [20:16], `rd` = [15:11].
  - `op==0`: R-type; reads `rs` and `rt`, writes `rd`.
  - `op!=0`: I-type; reads `rs`, writes `rt`.
  - A destination of r0 is never tracked (no write hazard).
- Accept: a push occurs when `in_valid && in_ready`. `in_ready = !full && rst`. No push when full, even if a pop happens in the same cycle.
- Scoreboard: a shift register of `HAZARD_DIST-1` destination entries.
  - Shifts every cycle, including during bubbles and while the FIFO is empty.
  - Slot 0 takes the destination of the word issued this edge, or 0 for a NOP.
- Hazard: the FIFO is non-empty and any read source of the head (nonzero) equals any nonzero scoreboard entry.
- Each cycle, the state machine is in exactly one of these states:
  - ISSUE: non-empty and no hazard. Pop the head, `instruction<=head`, `issued<=1`.
  - STALL: non-empty with a hazard. `instruction<=0`, `issued<=0`, `bubble_count++` (saturating).
  - IDLE: empty. `instruction<=0`, `issued<=0`, counter unchanged.
- Simultaneous push and pop when not full: both occur; occupancy is unchanged.
- Pointers wrap modulo `DEPTH`. Full and empty are distinguished by an extra pointer bit.

## Timing
- Reset (rst=0 at an edge) sets:
  - FIFO empty, `occupancy=0`, scoreboard all zero.
  - `instruction=0`, `issued=0`, `bubble_count=0`.
  - `in_ready=0` while rst is low.
  - Reset mid-stream discards all buffered and scoreboarded words; nothing is issued on the reset edge.
- Latency: a word accepted at edge t appears on `instruction` after edge t+1 at the earliest. There is no fall-through path.
- Throughput: one instruction per cycle with independent instructions.
- A dependent instruction that directly follows its producer gets `HAZARD_DIST-1` bubbles. With the default, that is 2 NOPs.
- `in_ready` and `occupancy` are derived combinationally from registered pointers. `instruction`, `issued` and `bubble_count` are registers.
- No combinational path from `in_valid` or `in_instr` to any output.

## Structure
- Package `issue_pkg`:
  - Field position constants (`OP_HI/LO`, `RS_HI/LO`, `RT_HI/LO`, `RD_HI/LO`).
  - `NOP_INSTR = 32'h0`.
  - `R_TYPE_OP = 6'd0`.
  - A function returning {src1, src2, src2_used, dest} for a word. The stage-1 decoder imports the same package.
- Sub-module `issue_fifo` (synchronous FIFO, parameter `DEPTH`, with push/pop/full/empty/count). The hazard and scoreboard logic stays in `instr_issue`.

## Test plan
- Reset then idle: hold rst=0 for 2 cycles, release with in_valid=0 → `instruction=0`, `issued=0`, `occupancy=0`, `in_ready=1` one cycle after release.
- Independent stream: push 0x00221800 (r3=r1+r2), then 0x20240005 (r4=r1+imm5) on consecutive cycles → issued back-to-back, `issued=1` for 2 cycles, `bubble_count=0`.
- RAW hazard: push 0x00221800 then 0x00622800 (reads r3) → output sequence 0x00221800, 0, 0, 0x00622800; `bubble_count=2`.
- r0 exemption: push 0x00000000 then 0x00001000 (rd=r2 ← r0+r0) → no bubbles.
- Full/backpressure: hold a hazard stall and push 5 words with DEPTH=4 → `in_ready=0` after the 4th accept, `occupancy=4`, 5th word held until a pop, then accepted, with no word lost or duplicated.
- Reset mid-operation: with 3 words buffered, assert rst for 1 cycle → `occupancy=0`, `instruction=0`, scoreboard clear; the next pushed dependent word issues with no bubble.
